// File: rtl/mips_datamem_responder.sv
// Word read/write data-memory responder (32 bytes, big-endian) with wait states and a held response.
// Optional misaligned-access checking is enabled by defining DATAMEM_ALIGN_CHECK_EN.
module mips_datamem_responder #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  busy_cnt
);

`ifdef DATAMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  busy_next;
    logic        wr_q;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  mem [32];
    logic        enter_resp;
    logic        misaligned;
    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic [4:0]  addr3;
    logic [31:0] rd_word;

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);
    assign enter_resp = (state == WAIT) && (busy_cnt == 4'd0);
    assign misaligned = ALIGN_CHECK && (addr_q[1:0] != 2'b00);

    // Byte addresses wrap naturally in 5 bits.
    assign addr1   = addr_q + 5'd1;
    assign addr2   = addr_q + 5'd2;
    assign addr3   = addr_q + 5'd3;
    assign rd_word = {mem[addr_q], mem[addr1], mem[addr2], mem[addr3]};

    always_comb begin
        state_next = state;
        busy_next  = busy_cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT;
                    busy_next  = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (busy_cnt == 4'd0) begin
                    state_next = RESP;
                end else begin
                    busy_next = busy_cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            busy_cnt <= busy_next;
        end
    end

    // Request capture, storage update and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            addr_q    <= 5'd0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (state == IDLE && req_valid) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rsp_err <= misaligned;
                if (wr_q) begin
                    rsp_rdata <= wdata_q;
                    if (!misaligned) begin
                        mem[addr_q] <= wdata_q[31:24];
                        mem[addr1]  <= wdata_q[23:16];
                        mem[addr2]  <= wdata_q[15:8];
                        mem[addr3]  <= wdata_q[7:0];
                    end
                end else begin
                    rsp_rdata <= misaligned ? 32'd0 : rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_datamem_responder.sv
// Directed bench for mips_datamem_responder: three instances with WAIT_CYCLES = 1, 0 and 3.
module tb_mips_datamem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [4:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic [3:0]  busy_cnt  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mips_datamem_responder #(
                .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .req_valid(req_valid[g]),
                .req_ready(req_ready[g]),
                .req_write(req_write[g]),
                .req_addr (req_addr[g]),
                .req_wdata(req_wdata[g]),
                .rsp_valid(rsp_valid[g]),
                .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]),
                .rsp_err  (rsp_err[g]),
                .busy_cnt (busy_cnt[g])
            );
        end
    endgenerate

    function automatic int wc(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic logic [7:0] mem_byte(input int i, input logic [4:0] a);
        case (i)
            0:       return g_dut[0].u_dut.mem[a];
            1:       return g_dut[1].u_dut.mem[a];
            default: return g_dut[2].u_dut.mem[a];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negative edge with the instance idle; returns the response fields.
    task automatic xfer(input int i, input logic wr, input logic [4:0] a, input logic [31:0] wd,
                        input string tag, output logic [31:0] rd, output logic er);
        int lat;
        int rdy_bad;
        chk({tag, "_ready_before"}, 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        rsp_ready[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
        lat = 0;
        rdy_bad = 0;
        do begin
            if (req_ready[i]) rdy_bad++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!rsp_valid[i] && lat < 40);
        if (req_ready[i]) rdy_bad++;
        chk({tag, "_latency"}, 32'(lat), 32'(wc(i) + 1));
        chk({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
        rd = rsp_rdata[i];
        er = rsp_err[i];
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid[i]), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready[i]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] held;
        int          wait_n;
        int          bad_valid;
        int          bad_ready;
        int          bad_data;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 5'd0;
            req_wdata[i] = 32'd0;
            rsp_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        chk("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
        chk("rst_busy_cnt",  32'(busy_cnt[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read, aligned.
        xfer(0, 1'b1, 5'd4, 32'hDEADBEEF, "wr4", rd, er);
        chk("wr4_echo", rd, 32'hDEADBEEF);
        chk("wr4_err", 32'(er), 32'd0);
        chk("wr4_bytes", {mem_byte(0, 5'd4), mem_byte(0, 5'd5), mem_byte(0, 5'd6), mem_byte(0, 5'd7)},
            32'hDEADBEEF);
        xfer(0, 1'b0, 5'd4, 32'd0, "rd4", rd, er);
        chk("rd4_data", rd, 32'hDEADBEEF);
        chk("rd4_err", 32'(er), 32'd0);

        // Wrap across the top of the address space.
        xfer(0, 1'b1, 5'd30, 32'h11223344, "wr30", rd, er);
        xfer(0, 1'b0, 5'd30, 32'd0, "rd30", rd, er);
`ifdef DATAMEM_ALIGN_CHECK_EN
        chk("wr30_bytes", {mem_byte(0, 5'd30), mem_byte(0, 5'd31), mem_byte(0, 5'd0), mem_byte(0, 5'd1)},
            32'h00000000);
        chk("rd30_data", rd, 32'h00000000);
        chk("rd30_err", 32'(er), 32'd1);
`else
        chk("wr30_bytes", {mem_byte(0, 5'd30), mem_byte(0, 5'd31), mem_byte(0, 5'd0), mem_byte(0, 5'd1)},
            32'h11223344);
        chk("rd30_data", rd, 32'h11223344);
        chk("rd30_err", 32'(er), 32'd0);
`endif

        // Backpressure: hold the read response for 6 cycles while a write is offered.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 5'd4;
        rsp_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_n = 0;
        while (!rsp_valid[0] && wait_n < 40) begin
            @(posedge clk);
            @(negedge clk);
            wait_n++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid[0]), 32'd1);
        held = rsp_rdata[0];
        chk("bp_data", held, 32'hDEADBEEF);
        bad_valid = 0;
        bad_ready = 0;
        bad_data  = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid[0] = 1'b1;
            req_write[0] = 1'b1;
            req_addr[0]  = 5'd4;
            req_wdata[0] = 32'h00000000;
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid[0] !== 1'b1) bad_valid++;
            if (req_ready[0] !== 1'b0) bad_ready++;
            if (rsp_rdata[0] !== held) bad_data++;
        end
        chk("bp_valid_held", 32'(bad_valid), 32'd0);
        chk("bp_ready_low", 32'(bad_ready), 32'd0);
        chk("bp_data_stable", 32'(bad_data), 32'd0);
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        chk("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
        chk("bp_release_ready", 32'(req_ready[0]), 32'd1);
        chk("bp_no_accept", {mem_byte(0, 5'd4), mem_byte(0, 5'd5), mem_byte(0, 5'd6), mem_byte(0, 5'd7)},
            32'hDEADBEEF);

        // Latency at zero and three wait states.
        xfer(1, 1'b0, 5'd0, 32'd0, "lat_w0", rd, er);
        chk("lat_w0_data", rd, 32'd0);
        xfer(2, 1'b0, 5'd0, 32'd0, "lat_w3", rd, er);
        chk("lat_w3_data", rd, 32'd0);

        // Reset while a write waits.
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 5'd8;
        req_wdata[2] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_in_wait", 32'(req_ready[2]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
        chk("mid_rst_ready", 32'(req_ready[2]), 32'd1);
        chk("mid_rst_busy", 32'(busy_cnt[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_byte8", 32'(mem_byte(2, 5'd8)), 32'd0);
        xfer(2, 1'b0, 5'd8, 32'd0, "mid_rd8", rd, er);
        chk("mid_rd8_data", rd, 32'h00000000);

        // Misaligned access.
        xfer(0, 1'b1, 5'd4, 32'hA1B2C3D4, "al_wr4", rd, er);
        xfer(0, 1'b1, 5'd8, 32'h55667788, "al_wr8", rd, er);
        xfer(0, 1'b1, 5'd5, 32'hFFFFFFFF, "al_wr5", rd, er);
        chk("al_wr5_echo", rd, 32'hFFFFFFFF);
`ifdef DATAMEM_ALIGN_CHECK_EN
        chk("al_wr5_err", 32'(er), 32'd1);
        chk("al_wr5_bytes", {mem_byte(0, 5'd5), mem_byte(0, 5'd6), mem_byte(0, 5'd7), mem_byte(0, 5'd8)},
            32'hB2C3D455);
        xfer(0, 1'b0, 5'd5, 32'd0, "al_rd5", rd, er);
        chk("al_rd5_data", rd, 32'h00000000);
        chk("al_rd5_err", 32'(er), 32'd1);
        xfer(0, 1'b0, 5'd4, 32'd0, "al_rd4", rd, er);
        chk("al_rd4_data", rd, 32'hA1B2C3D4);
        chk("al_rd4_err", 32'(er), 32'd0);
`else
        chk("al_wr5_err", 32'(er), 32'd0);
        chk("al_wr5_bytes", {mem_byte(0, 5'd5), mem_byte(0, 5'd6), mem_byte(0, 5'd7), mem_byte(0, 5'd8)},
            32'hFFFFFFFF);
        xfer(0, 1'b0, 5'd5, 32'd0, "al_rd5", rd, er);
        chk("al_rd5_data", rd, 32'hFFFFFFFF);
        chk("al_rd5_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 5'd4, 32'd0, "al_rd4", rd, er);
        chk("al_rd4_data", rd, 32'hA1FFFFFF);
        chk("al_rd4_err", 32'(er), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
